// File: rtl/dem_element_decoder_pkg.sv
// rtl/dem_element_decoder_pkg.sv - shared constants and FSM state type for the DEM element decoder
package dem_element_decoder_pkg;

   localparam int OUTPUT_WIDTH  = 3;
   localparam int MAX_LEVEL     = 7;
   localparam int DEM_NUM_ELEM  = MAX_LEVEL;
   localparam int DEM_CNT_WIDTH = 16;
   localparam int DEM_WINDOW    = 1024;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } dem_state_e;

endpackage

// File: rtl/dem_popcount.sv
// rtl/dem_popcount.sv - combinational popcount of a unit-element select vector
module dem_popcount
   import dem_element_decoder_pkg::*;
#(
   parameter int NUM_ELEM   = DEM_NUM_ELEM,
   parameter int CODE_WIDTH = OUTPUT_WIDTH
) (
   input  logic [NUM_ELEM-1:0]   sel_i,
   output logic [CODE_WIDTH-1:0] code_o
);

   always_comb begin
      code_o = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         code_o = code_o + CODE_WIDTH'(sel_i[i]);
      end
   end

endmodule

// File: rtl/dem_element_decoder.sv
// rtl/dem_element_decoder.sv - DEM select decode/check with windowed per-element usage counters
// Optional max-min usage scan enabled by defining DEM_SPREAD_CHECK_EN.
module dem_element_decoder
   import dem_element_decoder_pkg::*;
#(
   parameter int CODE_WIDTH = OUTPUT_WIDTH,
   parameter int NUM_ELEM   = DEM_NUM_ELEM,
   parameter int CNT_WIDTH  = DEM_CNT_WIDTH,
   parameter int WINDOW     = DEM_WINDOW,
   localparam int IDX_WIDTH = $clog2(NUM_ELEM)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_ELEM-1:0]   sel_i,
   input  logic [CODE_WIDTH-1:0] ref_code_i,
   input  logic                  sel_valid_i,
   input  logic                  start_i,
   input  logic                  clear_i,
   output logic [CODE_WIDTH-1:0] code_o,
   output logic                  code_valid_o,
   output logic                  mismatch_o,
   output logic                  err_sticky_o,
   output logic                  done_o,
   input  logic                  rd_req_i,
   input  logic [IDX_WIDTH-1:0]  rd_idx_i,
   output logic [CNT_WIDTH-1:0]  rd_data_o,
   output logic                  rd_valid_o,
   output logic [CNT_WIDTH-1:0]  spread_o
);

   localparam int WIN_W = $clog2(WINDOW + 1);

   logic [NUM_ELEM-1:0]   s1_sel_q;
   logic [CODE_WIDTH-1:0] s1_ref_q;
   logic                  s1_valid_q;
   logic [CODE_WIDTH-1:0] pop_d;
   logic [CODE_WIDTH-1:0] code_q;
   logic                  code_valid_q;
   logic                  mismatch_q;
   logic                  err_q;

   dem_state_e            state_q;
   logic [WIN_W-1:0]      win_q;
   logic [CNT_WIDTH-1:0]  cnt_q [NUM_ELEM];
   logic                  win_last;

   logic                  rd_valid_q;
   logic [CNT_WIDTH-1:0]  rd_data_q;

   dem_popcount #(
      .NUM_ELEM   (NUM_ELEM),
      .CODE_WIDTH (CODE_WIDTH)
   ) u_popcount (
      .sel_i  (s1_sel_q),
      .code_o (pop_d)
   );

   // Decode pipeline runs in every state, independent of the window FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sel_q     <= '0;
         s1_ref_q     <= '0;
         s1_valid_q   <= 1'b0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         mismatch_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         s1_sel_q     <= sel_i;
         s1_ref_q     <= ref_code_i;
         s1_valid_q   <= sel_valid_i;
         code_q       <= pop_d;
         code_valid_q <= s1_valid_q;
         mismatch_q   <= s1_valid_q && (pop_d != s1_ref_q);
         err_q        <= clear_i ? 1'b0 : (err_q | mismatch_q);
      end
   end

   assign win_last = (win_q == WIN_W'(WINDOW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         win_q   <= '0;
         for (int i = 0; i < NUM_ELEM; i++) cnt_q[i] <= '0;
      end else if (clear_i) begin
         state_q <= IDLE;
         win_q   <= '0;
         for (int i = 0; i < NUM_ELEM; i++) cnt_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) state_q <= ACCUM;
            end
            ACCUM: begin
               if (s1_valid_q) begin
                  for (int i = 0; i < NUM_ELEM; i++) begin
                     if (s1_sel_q[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
                        cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                     end
                  end
                  win_q <= win_q + WIN_W'(1);
                  if (win_last) state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Out-of-state or out-of-range reads still answer, with a zero count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_req_i;
         if (rd_req_i && (state_q == DONE) && (int'(rd_idx_i) < NUM_ELEM)) begin
            rd_data_q <= cnt_q[rd_idx_i];
         end else begin
            rd_data_q <= '0;
         end
      end
   end

`ifdef DEM_SPREAD_CHECK_EN
   logic                 enter_done;
   logic                 scan_busy_q;
   logic                 scan_fin_q;
   logic [IDX_WIDTH-1:0] scan_idx_q;
   logic [CNT_WIDTH-1:0] max_q;
   logic [CNT_WIDTH-1:0] min_q;
   logic [CNT_WIDTH-1:0] spread_q;

   assign enter_done = (state_q == ACCUM) && s1_valid_q && win_last && !clear_i;

   // One element per cycle, then one more cycle to form max-min.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_busy_q <= 1'b0;
         scan_fin_q  <= 1'b0;
         scan_idx_q  <= '0;
         max_q       <= '0;
         min_q       <= '0;
         spread_q    <= '0;
      end else if (clear_i) begin
         scan_busy_q <= 1'b0;
         scan_fin_q  <= 1'b0;
         scan_idx_q  <= '0;
         max_q       <= '0;
         min_q       <= '0;
         spread_q    <= '0;
      end else if (enter_done) begin
         scan_busy_q <= 1'b1;
         scan_idx_q  <= '0;
         max_q       <= '0;
         min_q       <= {CNT_WIDTH{1'b1}};
      end else if (scan_busy_q) begin
         if (cnt_q[scan_idx_q] > max_q) max_q <= cnt_q[scan_idx_q];
         if (cnt_q[scan_idx_q] < min_q) min_q <= cnt_q[scan_idx_q];
         scan_idx_q <= scan_idx_q + IDX_WIDTH'(1);
         if (int'(scan_idx_q) == NUM_ELEM - 1) begin
            scan_busy_q <= 1'b0;
            scan_fin_q  <= 1'b1;
         end
      end else if (scan_fin_q) begin
         spread_q   <= max_q - min_q;
         scan_fin_q <= 1'b0;
      end
   end

   assign spread_o = spread_q;
`else
   assign spread_o = '0;
`endif

   assign code_o       = code_q;
   assign code_valid_o = code_valid_q;
   assign mismatch_o   = mismatch_q;
   assign err_sticky_o = err_q;
   assign done_o       = (state_q == DONE);
   assign rd_valid_o   = rd_valid_q;
   assign rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_dem_element_decoder.sv
// tb/tb_dem_element_decoder.sv - self-checking bench for dem_element_decoder (WINDOW = 4)
module tb_dem_element_decoder;

   localparam int NE   = 7;
   localparam int CW   = 3;
   localparam int CNTW = 16;
   localparam int WIN  = 4;

   logic            clk;
   logic            rst_n;
   logic [NE-1:0]   sel_i;
   logic [CW-1:0]   ref_code_i;
   logic            sel_valid_i;
   logic            start_i;
   logic            clear_i;
   logic [CW-1:0]   code_o;
   logic            code_valid_o;
   logic            mismatch_o;
   logic            err_sticky_o;
   logic            done_o;
   logic            rd_req_i;
   logic [2:0]      rd_idx_i;
   logic [CNTW-1:0] rd_data_o;
   logic            rd_valid_o;
   logic [CNTW-1:0] spread_o;

   int checks   = 0;
   int failures = 0;

   dem_element_decoder #(
      .CODE_WIDTH (CW),
      .NUM_ELEM   (NE),
      .CNT_WIDTH  (CNTW),
      .WINDOW     (WIN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sel_i        (sel_i),
      .ref_code_i   (ref_code_i),
      .sel_valid_i  (sel_valid_i),
      .start_i      (start_i),
      .clear_i      (clear_i),
      .code_o       (code_o),
      .code_valid_o (code_valid_o),
      .mismatch_o   (mismatch_o),
      .err_sticky_o (err_sticky_o),
      .done_o       (done_o),
      .rd_req_i     (rd_req_i),
      .rd_idx_i     (rd_idx_i),
      .rd_data_o    (rd_data_o),
      .rd_valid_o   (rd_valid_o),
      .spread_o     (spread_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference: outputs are the inputs seen two edges earlier, decoded by popcount.
   logic [NE-1:0] m1_sel, m2_sel;
   logic [CW-1:0] m1_ref, m2_ref;
   logic          m1_v, m2_v, err_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1_sel <= '0; m1_ref <= '0; m1_v <= 1'b0;
         m2_sel <= '0; m2_ref <= '0; m2_v <= 1'b0;
         err_m  <= 1'b0;
      end else begin
         m1_sel <= sel_i; m1_ref <= ref_code_i; m1_v <= sel_valid_i;
         m2_sel <= m1_sel; m2_ref <= m1_ref; m2_v <= m1_v;
         if (clear_i) err_m <= 1'b0;
         else if (m2_v && ($countones(m2_sel) != int'(m2_ref))) err_m <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("code_valid", code_valid_o, m2_v);
         if (m2_v) begin
            chk("code", code_o, $countones(m2_sel));
            chk("mismatch", mismatch_o, $countones(m2_sel) != int'(m2_ref));
         end else begin
            chk("mismatch_idle", mismatch_o, 0);
         end
         chk("err_sticky", err_sticky_o, err_m);
`ifndef DEM_SPREAD_CHECK_EN
         chk("spread_off", spread_o, 0);
`endif
      end
   end

   // Usage model: the first WIN samples after a start are counted.
   int mcnt [NE];
   int mwin;
   bit mcounting;

   task automatic model_zero();
      for (int i = 0; i < NE; i++) mcnt[i] = 0;
      mwin = 0;
      mcounting = 0;
   endtask

   task automatic send(input logic [NE-1:0] s, input logic [CW-1:0] r);
      sel_i = s; ref_code_i = r; sel_valid_i = 1'b1;
      if (mcounting && mwin < WIN) begin
         for (int i = 0; i < NE; i++) if (s[i] && mcnt[i] < 65535) mcnt[i]++;
         mwin++;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      sel_valid_i = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_start(input bit counts);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (counts) mcounting = 1;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
      model_zero();
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done_o && n < 20) begin @(negedge clk); n++; end
      chk("done_rise", done_o, 1);
   endtask

   task automatic rd(input logic [2:0] idx, input int exp, input string name);
      rd_req_i = 1'b1;
      rd_idx_i = idx;
      @(posedge clk); @(negedge clk);
      chk({name, "_valid"}, rd_valid_o, 1);
      chk(name, rd_data_o, exp);
   endtask

   function automatic int model_spread();
      int mx = 0, mn = 65535;
      for (int i = 0; i < NE; i++) begin
         if (mcnt[i] > mx) mx = mcnt[i];
         if (mcnt[i] < mn) mn = mcnt[i];
      end
      return mx - mn;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1; sel_i = '0; ref_code_i = '0; sel_valid_i = 1'b0;
      start_i = 1'b0; clear_i = 1'b0; rd_req_i = 1'b0; rd_idx_i = '0;
      model_zero();
      #2 rst_n = 1'b0;
      #10;
      chk("rst_code_valid", code_valid_o, 0);
      chk("rst_mismatch", mismatch_o, 0);
      chk("rst_err", err_sticky_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rd_valid", rd_valid_o, 0);
      chk("rst_rd_data", rd_data_o, 0);
      chk("rst_spread", spread_o, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);

      // Matching code: latency exactly two edges
      send(7'b0101101, 3'd4);
      sel_valid_i = 1'b0;
      @(negedge clk); chk("lat_early", code_valid_o, 0);
      @(negedge clk);
      chk("a_valid", code_valid_o, 1);
      chk("a_code", code_o, 4);
      chk("a_mismatch", mismatch_o, 0);
      idle(1);

      // All-ones decodes to 7 without overflow; ref 6 mismatches
      send(7'b1111111, 3'd6);
      sel_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b_code", code_o, 7);
      chk("b_mismatch", mismatch_o, 1);
      chk("b_err_not_yet", err_sticky_o, 0);
      @(negedge clk); chk("b_err_set", err_sticky_o, 1);
      @(posedge clk); #1;
      idle(5);
      chk("b_err_held", err_sticky_o, 1);
      do_clear();
      @(negedge clk); chk("b_err_cleared", err_sticky_o, 0);

      // Async reset mid-ACCUM
      @(posedge clk); #1;
      do_start(1);
      send(7'b0000001, 3'd1);
      send(7'b0000001, 3'd1);
      idle(2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_code_valid", code_valid_o, 0);
      chk("mid_rst_code", code_o, 0);
      chk("mid_rst_done", done_o, 0);
      model_zero();
      @(posedge clk); #1 rst_n = 1'b1;

      // Full window of 7'b0000011
      do_start(1);
      for (int k = 0; k < WIN; k++) send(7'b0000011, 3'd2);
      sel_valid_i = 1'b0;
      wait_done();
      rd(3'd0, 4, "w_idx0");
      rd(3'd1, 4, "w_idx1");
      rd(3'd2, 0, "w_idx2");
      for (int i = 0; i < NE; i++) rd(3'(i), mcnt[i], "w_model");
      rd(3'd7, 0, "w_idx_oob");
      rd_req_i = 1'b0;
      @(posedge clk); #1;
      send(7'b0000011, 3'd2);
      idle(3);
      rd(3'd0, 4, "w5_idx0");
      rd(3'd1, 4, "w5_idx1");
      rd_req_i = 1'b0;
      do_start(0);
      @(negedge clk); chk("start_in_done", done_o, 1);

      // Read outside DONE returns zero
      @(posedge clk); #1;
      do_clear();
      chk("clr_done", done_o, 0);
      rd(3'd0, 0, "idle_rd");
      rd_req_i = 1'b0;

      // Clear coincident with a sample during ACCUM
      @(posedge clk); #1;
      do_start(1);
      send(7'b1111111, 3'd7);
      sel_i = 7'b0000001; ref_code_i = 3'd1; sel_valid_i = 1'b1; clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0; sel_valid_i = 1'b0;
      model_zero();
      @(negedge clk); chk("cs_done", done_o, 0);
      @(posedge clk); #1;
      idle(2);
      do_start(1);
      send(7'b0000111, 3'd3);
      send(7'b0000111, 3'd3);
      send(7'b0000011, 3'd2);
      send(7'b0000011, 3'd2);
      sel_valid_i = 1'b0;
      wait_done();
      repeat (7) @(posedge clk);
      @(negedge clk); chk("spread_early", spread_o, 0);
      @(negedge clk);
`ifdef DEM_SPREAD_CHECK_EN
      chk("spread_lit", spread_o, 4);
      chk("spread_model", spread_o, model_spread());
`else
      chk("spread_tied", spread_o, 0);
      chk("spread_model_nonzero", (model_spread() == 4), 1);
`endif
      rd(3'd0, 4, "cs_idx0");
      rd(3'd1, 4, "cs_idx1");
      rd(3'd2, 2, "cs_idx2");
      rd(3'd3, 0, "cs_idx3");
      for (int i = 0; i < NE; i++) rd(3'(i), mcnt[i], "cs_model");
      rd_req_i = 1'b0;
      @(posedge clk); #1;
      do_clear();
      @(negedge clk);
      chk("final_done", done_o, 0);
      chk("final_spread", spread_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
